// File: rtl/sobel_window_feeder.sv
// Streams a grayscale frame from synchronous memory as 3-pixel column vectors
// (top, centre, bottom) per column, framed per centre row for sobel_control.
module sobel_window_feeder #(
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8,
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   frame_start_i,
  output logic                   mem_rd_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic [PIXEL_WIDTH-1:0] mem_data_i,
  output logic                   start_sobel_o,
  output logic                   px_rdy_o,
  output logic [PIXEL_WIDTH-1:0] px_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 2);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] A_W    = ADDR_WIDTH'(IMG_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] A_BACK = ADDR_WIDTH'(2 * IMG_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, ROW_START, FEED, DRAIN, GAP, DONE} state_t;

  state_t                  state_q, state_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [1:0]              sub_q, sub_d;
  logic                    cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rd_d1_q, rd_d1_d;
  logic                    px_rdy_q, px_rdy_d;
  logic [PIXEL_WIDTH-1:0]  px_q, px_d;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      sub_q    <= '0;
      cnt_q    <= 1'b0;
      base_q   <= '0;
      addr_q   <= '0;
      rd_d1_q  <= 1'b0;
      px_rdy_q <= 1'b0;
      px_q     <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      sub_q    <= sub_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      rd_d1_q  <= rd_d1_d;
      px_rdy_q <= px_rdy_d;
      px_q     <= px_d;
    end
  end

  // base_q tracks (row-1)*IMG_WIDTH; addr_q walks down a column, then steps
  // back two rows and right one column, so no multiplier is needed.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          state_d = ROW_START;
          row_d   = RW'(1);
          col_d   = '0;
          sub_d   = '0;
          base_d  = '0;
          addr_d  = '0;
        end
      end
      ROW_START: begin
        state_d = FEED;
        col_d   = '0;
        sub_d   = '0;
        addr_d  = base_q;
      end
      FEED: begin
        if (sub_q == 2'd2) begin
          sub_d = '0;
          if (col_q == LAST_COL) begin
            state_d = DRAIN;
            cnt_d   = 1'b0;
          end else begin
            col_d  = col_q + CW'(1);
            addr_d = addr_q - A_BACK;
          end
        end else begin
          sub_d  = sub_q + 2'd1;
          addr_d = addr_q + A_W;
        end
      end
      DRAIN: begin
        cnt_d = ~cnt_q;
        if (cnt_q) state_d = GAP;
      end
      GAP: begin
        cnt_d = ~cnt_q;
        if (cnt_q) begin
          if (row_q == LAST_ROW) begin
            state_d = DONE;
          end else begin
            state_d = ROW_START;
            row_d   = row_q + RW'(1);
            col_d   = '0;
            base_d  = base_q + A_W;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel path: memory data is valid one cycle after the read, registered once more.
  always_comb begin
    rd_d1_d  = mem_rd_o;
    px_rdy_d = rd_d1_q;
    px_d     = rd_d1_q ? mem_data_i : px_q;
  end

  assign mem_rd_o      = (state_q == FEED);
  assign mem_addr_o    = mem_rd_o ? addr_q : '0;
  assign start_sobel_o = (state_q == ROW_START) || (state_q == FEED) || (state_q == DRAIN);
  assign busy_o        = (state_q != IDLE);
  assign frame_done_o  = (state_q == DONE);
  assign px_rdy_o      = px_rdy_q;
  assign px_o          = px_q;

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Directed bench for sobel_window_feeder: 3x3, 5x4 and 4x3 instances with
// behavioural synchronous memories and negedge monitors.
module tb_sobel_window_feeder;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_px[9]   = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
  int exp_addr[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};

  // ---------------- instance A: 3x3 ----------------
  logic a_fs, a_rd, a_ss, a_prdy, a_busy, a_done;
  logic a_ssp = 1'b0;
  logic [5:0] a_addr;
  logic [7:0] a_din, a_px;
  logic [7:0] a_mem [64];
  sobel_window_feeder #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .PIXEL_WIDTH(8), .ADDR_WIDTH(6)) u_a (
    .clk_i(clk), .nreset_i(nreset), .frame_start_i(a_fs), .mem_rd_o(a_rd), .mem_addr_o(a_addr),
    .mem_data_i(a_din), .start_sobel_o(a_ss), .px_rdy_o(a_prdy), .px_o(a_px), .busy_o(a_busy),
    .frame_done_o(a_done));
  always @(posedge clk) if (a_rd) a_din <= a_mem[a_addr];
  int a_addrq[$], a_rdc[$], a_pxq[$], a_pxc[$], a_donec[$], a_rise[$], a_fall[$];
  int a_busy_n = 0;
  always @(negedge clk) begin
    if (a_rd) begin a_addrq.push_back(int'(a_addr)); a_rdc.push_back(cyc); end
    if (a_prdy) begin a_pxq.push_back(int'(a_px)); a_pxc.push_back(cyc); end
    if (a_done) a_donec.push_back(cyc);
    if (a_busy) a_busy_n = a_busy_n + 1;
    if (a_ss && !a_ssp) a_rise.push_back(cyc);
    if (!a_ss && a_ssp) a_fall.push_back(cyc);
    a_ssp = a_ss;
  end

  // ---------------- instance B: 5 wide x 4 high ----------------
  logic b_fs, b_rd, b_ss, b_prdy, b_busy, b_done;
  logic b_ssp = 1'b0;
  logic [5:0] b_addr;
  logic [7:0] b_din, b_px;
  logic [7:0] b_mem [64];
  sobel_window_feeder #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .PIXEL_WIDTH(8), .ADDR_WIDTH(6)) u_b (
    .clk_i(clk), .nreset_i(nreset), .frame_start_i(b_fs), .mem_rd_o(b_rd), .mem_addr_o(b_addr),
    .mem_data_i(b_din), .start_sobel_o(b_ss), .px_rdy_o(b_prdy), .px_o(b_px), .busy_o(b_busy),
    .frame_done_o(b_done));
  always @(posedge clk) if (b_rd) b_din <= b_mem[b_addr];
  int b_addrq[$], b_pxq[$], b_pxc[$], b_donec[$], b_rise[$], b_fall[$];
  int b_busy_n = 0;
  always @(negedge clk) begin
    if (b_rd) b_addrq.push_back(int'(b_addr));
    if (b_prdy) begin b_pxq.push_back(int'(b_px)); b_pxc.push_back(cyc); end
    if (b_done) b_donec.push_back(cyc);
    if (b_busy) b_busy_n = b_busy_n + 1;
    if (b_ss && !b_ssp) b_rise.push_back(cyc);
    if (!b_ss && b_ssp) b_fall.push_back(cyc);
    b_ssp = b_ss;
  end

  // ---------------- instance C: 4 wide x 3 high ----------------
  logic c_fs, c_rd, c_ss, c_prdy, c_busy, c_done;
  logic [5:0] c_addr;
  logic [7:0] c_din, c_px;
  logic [7:0] c_mem [64];
  sobel_window_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .PIXEL_WIDTH(8), .ADDR_WIDTH(6)) u_c (
    .clk_i(clk), .nreset_i(nreset), .frame_start_i(c_fs), .mem_rd_o(c_rd), .mem_addr_o(c_addr),
    .mem_data_i(c_din), .start_sobel_o(c_ss), .px_rdy_o(c_prdy), .px_o(c_px), .busy_o(c_busy),
    .frame_done_o(c_done));
  always @(posedge clk) if (c_rd) c_din <= c_mem[c_addr];
  int c_pxq[$], c_donec[$];
  always @(negedge clk) begin
    if (c_prdy) c_pxq.push_back(int'(c_px));
    if (c_done) c_donec.push_back(cyc);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_a();
    a_addrq.delete(); a_rdc.delete(); a_pxq.delete(); a_pxc.delete();
    a_donec.delete(); a_rise.delete(); a_fall.delete();
  endtask

  task automatic clr_b();
    b_addrq.delete(); b_pxq.delete(); b_pxc.delete();
    b_donec.delete(); b_rise.delete(); b_fall.delete();
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    tick(2);
    vec++;
    if ({a_rd, a_addr, a_ss, a_prdy, a_px, a_busy, a_done} !== 19'd0) begin
      err++; $display("FAIL reset_a outputs=%h required 0", {a_rd, a_addr, a_ss, a_prdy, a_px, a_busy, a_done});
    end
    vec++;
    if ({b_rd, b_addr, b_ss, b_prdy, b_px, b_busy, b_done} !== 19'd0) begin
      err++; $display("FAIL reset_b outputs=%h required 0", {b_rd, b_addr, b_ss, b_prdy, b_px, b_busy, b_done});
    end
    vec++;
    if ({c_rd, c_addr, c_ss, c_prdy, c_px, c_busy, c_done} !== 19'd0) begin
      err++; $display("FAIL reset_c outputs=%h required 0", {c_rd, c_addr, c_ss, c_prdy, c_px, c_busy, c_done});
    end
    nreset = 1'b1;
    tick(2);
  endtask

  task automatic test_3x3();
    int k, b0;
    for (int i = 0; i < 9; i++) a_mem[i] = 8'(i + 1);
    clr_a();
    b0 = a_busy_n;
    a_fs = 1'b1; tick(); a_fs = 1'b0;
    k = 0;
    while (!a_done && k < 40) begin tick(); k++; end
    vec++;
    if (!a_done) begin err++; $display("FAIL 3x3_done_timeout got no frame_done_o within 40 cycles"); end
    tick(4);
    vec++;
    if (a_pxq.size() != 9) begin err++; $display("FAIL 3x3_px_count got %0d required 9", a_pxq.size()); end
    for (int i = 0; i < 9; i++) begin
      vec++;
      if (a_pxq[i] !== exp_px[i]) begin err++; $display("FAIL 3x3_px[%0d] got %0d required %0d", i, a_pxq[i], exp_px[i]); end
      vec++;
      if (a_addrq[i] !== exp_addr[i]) begin err++; $display("FAIL 3x3_addr[%0d] got %0d required %0d", i, a_addrq[i], exp_addr[i]); end
      vec++;
      if (a_pxc[i] - a_rdc[i] != 2) begin err++; $display("FAIL 3x3_latency[%0d] got %0d required 2", i, a_pxc[i] - a_rdc[i]); end
    end
    vec++;
    if (a_rdc[0] - a_rise[0] != 1) begin err++; $display("FAIL 3x3_first_rd got %0d cycles after ROW_START required 1", a_rdc[0] - a_rise[0]); end
    vec++;
    if (a_donec.size() != 1 || a_donec[0] - a_rise[0] != 14) begin
      err++; $display("FAIL 3x3_done_time got %0d pulses at +%0d required 1 at +14", a_donec.size(), a_donec[0] - a_rise[0]);
    end
    vec++;
    if (a_fall[0] != a_pxc[8] + 1) begin err++; $display("FAIL 3x3_start_fall got %0d required %0d", a_fall[0], a_pxc[8] + 1); end
    vec++;
    if (a_busy_n - b0 != 15) begin err++; $display("FAIL 3x3_busy_cycles got %0d required 15", a_busy_n - b0); end
  endtask

  task automatic test_5x4();
    int k, b0, n, row1;
    for (int i = 0; i < 20; i++) b_mem[i] = 8'(i);
    clr_b();
    b0 = b_busy_n;
    b_fs = 1'b1; tick(); b_fs = 1'b0;
    k = 0;
    while (!b_done && k < 80) begin tick(); k++; end
    vec++;
    if (!b_done) begin err++; $display("FAIL 5x4_done_timeout got no frame_done_o within 80 cycles"); end
    tick(4);
    vec++;
    if (b_addrq.size() != 30 || b_pxq.size() != 30) begin
      err++; $display("FAIL 5x4_count got %0d reads %0d strobes required 30", b_addrq.size(), b_pxq.size());
    end
    n = 0;
    for (int r = 1; r <= 2; r++)
      for (int c = 0; c < 5; c++)
        for (int s = 0; s < 3; s++) begin
          vec++;
          if (b_addrq[n] !== (r - 1 + s) * 5 + c) begin
            err++; $display("FAIL 5x4_addr[%0d] got %0d required %0d", n, b_addrq[n], (r - 1 + s) * 5 + c);
          end
          vec++;
          if (b_pxq[n] !== (r - 1 + s) * 5 + c) begin
            err++; $display("FAIL 5x4_px[%0d] got %0d required %0d", n, b_pxq[n], (r - 1 + s) * 5 + c);
          end
          n++;
        end
    row1 = 0;
    foreach (b_pxc[i]) if (b_pxc[i] < b_rise[1]) row1++;
    vec++;
    if (row1 != 15) begin err++; $display("FAIL 5x4_row1_strobes got %0d required 15", row1); end
    vec++;
    if (b_rise.size() != 2 || b_rise[1] - b_fall[0] != 2) begin
      err++; $display("FAIL 5x4_gap got %0d rows gap %0d required 2 rows gap 2", b_rise.size(), b_rise[1] - b_fall[0]);
    end
    vec++;
    if (b_busy_n - b0 != 41) begin err++; $display("FAIL 5x4_busy_cycles got %0d required 41", b_busy_n - b0); end
    vec++;
    if (b_donec.size() != 1) begin err++; $display("FAIL 5x4_done_count got %0d required 1", b_donec.size()); end
  endtask

  task automatic test_ignored_start();
    int k;
    clr_a();
    a_fs = 1'b1; tick(); a_fs = 1'b0;
    tick();
    a_fs = 1'b1; tick(); a_fs = 1'b0;
    k = 0;
    while (!a_done && k < 40) begin tick(); k++; end
    vec++;
    if (!a_done) begin err++; $display("FAIL ign_done_timeout got no frame_done_o within 40 cycles"); end
    tick(10);
    vec++;
    if (a_pxq.size() != 9) begin err++; $display("FAIL ign_px_count got %0d required 9", a_pxq.size()); end
    for (int i = 0; i < 9; i++) begin
      vec++;
      if (a_pxq[i] !== exp_px[i]) begin err++; $display("FAIL ign_px[%0d] got %0d required %0d", i, a_pxq[i], exp_px[i]); end
    end
    vec++;
    if (a_donec.size() != 1 || a_rise.size() != 1) begin
      err++; $display("FAIL ign_frames got %0d done %0d rows required 1 1", a_donec.size(), a_rise.size());
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clr_b();
    b_fs = 1'b1; tick(); b_fs = 1'b0;
    k = 0;
    while (!(b_rd && b_addr == 6'd2) && k < 40) begin tick(); k++; end
    vec++;
    if (!(b_rd && b_addr == 6'd2)) begin err++; $display("FAIL rstmid_reach got no read of address 2"); end
    nreset = 1'b0;
    #1;
    vec++;
    if ({b_rd, b_addr, b_ss, b_prdy, b_px, b_busy, b_done} !== 19'd0) begin
      err++; $display("FAIL rstmid_outputs got %h required 0", {b_rd, b_addr, b_ss, b_prdy, b_px, b_busy, b_done});
    end
    tick();
    vec++;
    if ({b_rd, b_addr, b_ss, b_prdy, b_px, b_busy, b_done} !== 19'd0) begin
      err++; $display("FAIL rstmid_next_cycle got %h required 0", {b_rd, b_addr, b_ss, b_prdy, b_px, b_busy, b_done});
    end
    nreset = 1'b1;
    tick(2);
    vec++;
    if (b_busy !== 1'b0) begin err++; $display("FAIL rstmid_idle busy=%0b required 0", b_busy); end
    clr_b();
    b_fs = 1'b1; tick(); b_fs = 1'b0;
    k = 0;
    while (!b_done && k < 80) begin tick(); k++; end
    vec++;
    if (!b_done) begin err++; $display("FAIL rstmid_done_timeout got no frame_done_o within 80 cycles"); end
    tick(4);
    vec++;
    if (b_addrq.size() != 30 || b_addrq[0] !== 0 || b_addrq[29] !== 19) begin
      err++; $display("FAIL rstmid_restream got %0d reads first %0d last %0d required 30 0 19",
                      b_addrq.size(), b_addrq[0], b_addrq[29]);
    end
  endtask

  task automatic test_back_to_back();
    int k, nd;
    clr_a();
    a_fs = 1'b1;
    k = 0; nd = 0;
    while (nd < 2 && k < 100) begin
      tick(); k++;
      if (a_done) nd++;
    end
    a_fs = 1'b0;
    vec++;
    if (nd != 2) begin err++; $display("FAIL b2b_done_timeout got %0d done pulses required 2", nd); end
    tick(6);
    vec++;
    if (a_pxq.size() != 18) begin err++; $display("FAIL b2b_px_count got %0d required 18", a_pxq.size()); end
    for (int i = 0; i < 9; i++) begin
      vec++;
      if (a_pxq[i] !== exp_px[i] || a_pxq[i + 9] !== exp_px[i]) begin
        err++; $display("FAIL b2b_px[%0d] got %0d/%0d required %0d", i, a_pxq[i], a_pxq[i + 9], exp_px[i]);
      end
    end
    vec++;
    if (a_rise.size() != 2 || a_donec.size() != 2 || a_rise[1] - a_donec[0] != 2) begin
      err++; $display("FAIL b2b_restart got rows %0d dones %0d restart +%0d required 2 2 +2",
                      a_rise.size(), a_donec.size(), a_rise[1] - a_donec[0]);
    end
  endtask

  task automatic test_e2e_step();
    int k, gx, gy, mag;
    int p[3][3];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) c_mem[r * 4 + c] = (c >= 2) ? 8'd200 : 8'd0;
    c_pxq.delete(); c_donec.delete();
    c_fs = 1'b1; tick(); c_fs = 1'b0;
    k = 0;
    while (!c_done && k < 40) begin tick(); k++; end
    vec++;
    if (!c_done) begin err++; $display("FAIL e2e_done_timeout got no frame_done_o within 40 cycles"); end
    tick(4);
    vec++;
    if (c_pxq.size() != 12) begin err++; $display("FAIL e2e_px_count got %0d required 12", c_pxq.size()); end
    for (int m = 0; m < 2; m++) begin
      for (int cc = 0; cc < 3; cc++)
        for (int rr = 0; rr < 3; rr++) p[rr][cc] = c_pxq[3 * (m + cc) + rr];
      gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
      gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      vec++;
      if (mag != 800) begin err++; $display("FAIL e2e_sobel[%0d] got %0d required 800", m, mag); end
    end
  endtask

  initial begin
    a_fs = 1'b0; b_fs = 1'b0; c_fs = 1'b0;
    test_reset();
    test_3x3();
    test_5x4();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_e2e_step();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
